// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, operation encoding and read-modify-write helper.
package csr_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_TOHOST    = 12'h51E;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TOHOST,
    SEL_SCRATCH,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_INS_LO,
    SEL_INS_HI
  } csr_sel_e;

  function automatic logic [XLEN-1:0] csr_rmw(input csr_op_e op,
                                              input logic [XLEN-1:0] old_val,
                                              input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running/event counter with independently writable 32-bit halves.
module csr_counter64
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     q
);

  // A write in the same cycle as an increment wins; the increment is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) q[31:0]  <= wdata;
      if (wr_hi) q[63:32] <= wdata;
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/csr_tohost_unit.sv
// CSR unit: tohost, mscratch, cycle and instret counters with one-cycle response.
// Optional macro CSR_INSTRET_EN adds the instret counter storage.
module csr_tohost_unit
  import csr_pkg::*;
#(
  parameter logic [11:0]     TOHOST_ADDR  = CSR_TOHOST,
  parameter logic [11:0]     SCRATCH_ADDR = CSR_MSCRATCH,
  parameter logic [XLEN-1:0] TOHOST_RST   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [11:0]     req_addr,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_wr_en,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            retire,
  output logic [XLEN-1:0] tohost
);

  csr_op_e         op;
  csr_sel_e        sel;
  logic            read_only;
  logic            illegal;
  logic            accept;
  logic            do_write;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] mscratch;
  logic [63:0]     cyc_q;
  logic [63:0]     ins_q;

  assign op       = csr_op_e'(req_op);
  assign accept   = req_valid && req_ready;
  assign do_write = accept && req_wr_en && !illegal;
  assign new_val  = csr_rmw(op, old_val, req_wdata);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    sel       = SEL_NONE;
    read_only = 1'b0;
    if (req_addr == TOHOST_ADDR) begin
      sel = SEL_TOHOST;
    end else if (req_addr == SCRATCH_ADDR) begin
      sel = SEL_SCRATCH;
    end else begin
      case (req_addr)
        CSR_CYCLE, CSR_TIME:   begin sel = SEL_CYC_LO; read_only = 1'b1; end
        CSR_CYCLEH, CSR_TIMEH: begin sel = SEL_CYC_HI; read_only = 1'b1; end
        CSR_INSTRET:           begin sel = SEL_INS_LO; read_only = 1'b1; end
        CSR_INSTRETH:          begin sel = SEL_INS_HI; read_only = 1'b1; end
        CSR_MCYCLE:            sel = SEL_CYC_LO;
        CSR_MCYCLEH:           sel = SEL_CYC_HI;
        CSR_MINSTRET:          sel = SEL_INS_LO;
        CSR_MINSTRETH:         sel = SEL_INS_HI;
        default:               sel = SEL_NONE;
      endcase
    end

    case (sel)
      SEL_TOHOST:  old_val = tohost;
      SEL_SCRATCH: old_val = mscratch;
      SEL_CYC_LO:  old_val = cyc_q[31:0];
      SEL_CYC_HI:  old_val = cyc_q[63:32];
      SEL_INS_LO:  old_val = ins_q[31:0];
      SEL_INS_HI:  old_val = ins_q[63:32];
      default:     old_val = '0;
    endcase

    illegal = (sel == SEL_NONE) || (op == CSR_OP_RSVD) || (read_only && req_wr_en);
  end

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (do_write && sel == SEL_CYC_LO),
    .wr_hi (do_write && sel == SEL_CYC_HI),
    .wdata (new_val),
    .q     (cyc_q)
  );

`ifdef CSR_INSTRET_EN
  csr_counter64 u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .wr_lo (do_write && sel == SEL_INS_LO),
    .wr_hi (do_write && sel == SEL_INS_HI),
    .wdata (new_val),
    .q     (ins_q)
  );
`else
  // Without storage the instret addresses decode but read zero and drop writes.
  logic unused_retire;
  assign unused_retire = retire;
  assign ins_q         = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost      <= TOHOST_RST;
      mscratch    <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      req_ready <= !accept;
      rsp_valid <= accept;
      if (accept) begin
        rsp_rdata   <= illegal ? '0 : old_val;
        rsp_illegal <= illegal;
      end
      if (do_write && sel == SEL_TOHOST)  tohost   <= new_val;
      if (do_write && sel == SEL_SCRATCH) mscratch <= new_val;
    end
  end

endmodule

// File: tb/tb_csr_tohost_unit.sv
// Directed and randomized bench for csr_tohost_unit against an architectural CSR model.
module tb_csr_tohost_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_op = '0;
  logic [31:0] req_wdata = '0;
  logic        req_wr_en = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        retire = 1'b0;
  logic [31:0] tohost;

  int tests = 0;
  int fails = 0;

  // Architectural model state
  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_tohost, m_scratch;
  logic        m_ready;
  logic        e_valid, e_ill;
  logic [31:0] e_rd;

  logic [11:0] addrs [16] = '{12'h51E, 12'h340, 12'hC00, 12'hC01, 12'hC02, 12'hC80,
                              12'hC81, 12'hC82, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                              12'h123, 12'h7FF, 12'h340, 12'h51E};

  csr_tohost_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_op      (req_op),
    .req_wdata   (req_wdata),
    .req_wr_en   (req_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_illegal (rsp_illegal),
    .retire      (retire),
    .tohost      (tohost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view of an address: target register, read-only flag, current value.
  function automatic void m_lookup(input logic [11:0] a, output int tgt,
                                   output logic ro, output logic [31:0] val);
    tgt = -1; ro = 1'b0; val = '0;
    case (a)
      12'h51E:          begin tgt = 1; val = m_tohost; end
      12'h340:          begin tgt = 2; val = m_scratch; end
      12'hC00, 12'hC01: begin tgt = 3; ro = 1'b1; val = m_cycle[31:0]; end
      12'hB00:          begin tgt = 3; val = m_cycle[31:0]; end
      12'hC80, 12'hC81: begin tgt = 4; ro = 1'b1; val = m_cycle[63:32]; end
      12'hB80:          begin tgt = 4; val = m_cycle[63:32]; end
      12'hC02:          begin tgt = 5; ro = 1'b1; val = m_instret[31:0]; end
      12'hB02:          begin tgt = 5; val = m_instret[31:0]; end
      12'hC82:          begin tgt = 6; ro = 1'b1; val = m_instret[63:32]; end
      12'hB82:          begin tgt = 6; val = m_instret[63:32]; end
      default:          ;
    endcase
  endfunction

  task automatic model_reset();
    m_cycle = '0; m_instret = '0; m_tohost = '0; m_scratch = '0;
    m_ready = 1'b1; e_valid = 1'b0; e_ill = 1'b0; e_rd = '0;
  endtask

  // One clock: predict, advance, then compare outputs 1ns after the edge.
  task automatic step();
    logic [63:0] n_cyc, n_ins;
    logic [31:0] n_toh, n_scr, old, nv;
    logic        ro, ill, acc;
    int          tgt;
    acc   = req_valid && m_ready;
    n_cyc = m_cycle + 64'd1;
`ifdef CSR_INSTRET_EN
    n_ins = m_instret + (retire ? 64'd1 : 64'd0);
`else
    n_ins = '0;
`endif
    n_toh = m_tohost; n_scr = m_scratch; nv = '0;
    if (acc) begin
      m_lookup(req_addr, tgt, ro, old);
      ill = (tgt < 0) || (req_op == 2'b00) || (ro && req_wr_en);
      if (!ill && req_wr_en) begin
        case (req_op)
          2'b01:   nv = req_wdata;
          2'b10:   nv = old | req_wdata;
          default: nv = old & ~req_wdata;
        endcase
        case (tgt)
          1: n_toh = nv;
          2: n_scr = nv;
          3: n_cyc = {m_cycle[63:32], nv};
          4: n_cyc = {nv, m_cycle[31:0]};
`ifdef CSR_INSTRET_EN
          5: n_ins = {m_instret[63:32], nv};
          6: n_ins = {nv, m_instret[31:0]};
`endif
          default: ;
        endcase
      end
      e_rd  = ill ? 32'd0 : old;
      e_ill = ill;
    end
    e_valid = acc;
    m_ready = !acc;
    @(posedge clk); #1;
    m_cycle = n_cyc; m_instret = n_ins; m_tohost = n_toh; m_scratch = n_scr;
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, e_valid});
    chk("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
    chk("tohost", {32'd0, tohost}, {32'd0, m_tohost});
    if (e_valid) begin
      chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e_rd});
      chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e_ill});
    end
  endtask

  // Present a request, wait out a not-ready cycle if needed, return after the response edge.
  task automatic req(input logic [11:0] a, input logic [1:0] op,
                     input logic [31:0] wd, input logic we);
    req_valid = 1'b1; req_addr = a; req_op = op; req_wdata = wd; req_wr_en = we;
    if (!m_ready) step();
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; retire = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_reset();
    chk("rst_tohost", {32'd0, tohost}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    // 1: reset and first counter read
    do_reset();
    req(12'hC00, 2'b10, 32'd0, 1'b0);
    chk("first_cycle_read", {32'd0, rsp_rdata}, 64'd0);

    // 5: instret counts retire pulses, read sees pre-increment value
    retire = 1'b1;
    repeat (10) step();
    req(12'hC02, 2'b10, 32'd0, 1'b0);
    retire = 1'b0;
`ifdef CSR_INSTRET_EN
    chk("instret_10", {32'd0, rsp_rdata}, 64'd10);
`else
    chk("instret_absent", {32'd0, rsp_rdata}, 64'd0);
`endif

    // 2: tohost writes
    req(12'h51E, 2'b01, 32'd1, 1'b1);
    chk("tohost_old0", {32'd0, rsp_rdata}, 64'd0);
    step();
    chk("tohost_is1", {32'd0, tohost}, 64'd1);
    req(12'h51E, 2'b01, 32'd3, 1'b1);
    chk("tohost_old1", {32'd0, rsp_rdata}, 64'd1);
    step();
    chk("tohost_is3", {32'd0, tohost}, 64'd3);

    // 3: mscratch set/clear
    req(12'h340, 2'b01, 32'hF0F0_F0F0, 1'b1);
    req(12'h340, 2'b10, 32'h0000_000F, 1'b1);
    chk("rs_old", {32'd0, rsp_rdata}, 64'hF0F0_F0F0);
    req(12'h340, 2'b11, 32'hF000_0000, 1'b1);
    chk("rc_old", {32'd0, rsp_rdata}, 64'hF0F0_F0FF);
    req(12'h340, 2'b10, 32'd0, 1'b0);
    chk("rc_result", {32'd0, rsp_rdata}, 64'h00F0_F0FF);

    // 4: cycle wrap and read-only protection
    req(12'hB00, 2'b01, 32'hFFFF_FFFE, 1'b1);
    req(12'hB80, 2'b01, 32'hFFFF_FFFF, 1'b1);
    repeat (3) step();
    req(12'hC80, 2'b10, 32'd0, 1'b0);
    chk("cycleh_wrapped", {32'd0, rsp_rdata}, 64'd0);
    req(12'hC00, 2'b10, 32'd0, 1'b0);
    chk("cycle_small", {63'd0, rsp_rdata < 32'd16}, 64'd1);
    req(12'hC00, 2'b01, 32'h1234_5678, 1'b1);
    chk("c00_write_illegal", {63'd0, rsp_illegal}, 64'd1);
    chk("c00_write_rdata", {32'd0, rsp_rdata}, 64'd0);
    req(12'hC00, 2'b10, 32'd0, 1'b0);
    chk("c00_pure_read_legal", {63'd0, rsp_illegal}, 64'd0);
    req(12'h340, 2'b00, 32'd5, 1'b1);
    chk("rsvd_op_illegal", {63'd0, rsp_illegal}, 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        retire = 1'($urandom_range(0, 1));
        step();
      end
      retire = 1'($urandom_range(0, 1));
      req(addrs[$urandom_range(0, 15)], 2'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 1)));
    end
    retire = 1'b0;

    // 6: reset lands on the accept edge of a tohost write
    do_reset();
    step();
    req_valid = 1'b1; req_addr = 12'h51E; req_op = 2'b01; req_wdata = 32'd1; req_wr_en = 1'b1;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_tohost", {32'd0, tohost}, 64'd0);
    chk("rst_mid_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    step();
    step();
    chk("after_rst_tohost", {32'd0, tohost}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
